psg_shaper_sched: RTL and testbench

- Time-multiplexes one registered 12x8 multiplier across NCH PSG voices. It replaces NCH parallel per-voice shapers.
- On each sample tick it snapshots every voice's tone and envelope, then issues one voice per cycle to the shared multiplier. Each product lands in that voice's output register.
- Sits between the tone/envelope generators and the mixer. Signals completion of a sample frame with a one-cycle strobe.

---
 rtl/psg_pkg.sv | 14 +
 rtl/psg_shaper_mul.sv | 46 ++++
 rtl/psg_shaper_sched.sv | 174 +++++++++++++++++
 tb/tb_psg_shaper_sched.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/psg_pkg.sv
// Shared types and widths for the PSG voice shaper scheduler.
package psg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } psg_sched_state_e;

    localparam int PSG_TW = 12;
    localparam int PSG_EW = 8;
    localparam int PSG_OW = PSG_TW + PSG_EW;

endpackage

// File: rtl/psg_shaper_mul.sv
// Registered unsigned multiplier with tag/valid sideband, one cycle of latency.
module psg_shaper_mul
    import psg_pkg::*;
#(
    parameter int AW  = PSG_TW,
    parameter int BW  = PSG_EW,
    parameter int TGW = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [AW-1:0]        a_i,
    input  logic [BW-1:0]        b_i,
    input  logic [TGW-1:0]       tag_i,
    input  logic                 vld_i,
    output logic [AW+BW-1:0]     prod_o,
    output logic [TGW-1:0]       tag_o,
    output logic                 vld_o
);

    logic [AW+BW-1:0] prod_q;
    logic [TGW-1:0]   tag_q;
    logic             vld_q;
    logic [AW+BW-1:0] a_ext;
    logic [AW+BW-1:0] b_ext;

    // Zero-extend both operands so the product is formed at full width.
    assign a_ext = {{BW{1'b0}}, a_i};
    assign b_ext = {{AW{1'b0}}, b_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prod_q <= '0;
            tag_q  <= '0;
            vld_q  <= 1'b0;
        end else begin
            prod_q <= a_ext * b_ext;
            tag_q  <= tag_i;
            vld_q  <= vld_i;
        end
    end

    assign prod_o = prod_q;
    assign tag_o  = tag_q;
    assign vld_o  = vld_q;

endmodule

// File: rtl/psg_shaper_sched.sv
// Time-multiplexes one 12x8 multiplier across NCH PSG voices per sample tick.
// Optional mix_o sum output is built when PSG_SHAPER_SCHED_MIX_EN is defined.
//
// state | meaning
// IDLE  | waiting for ce; snapshots voice inputs when it arrives
// RUN   | issuing one voice per cycle to the multiplier
// DRAIN | last product writes back; done_o pulses
module psg_shaper_sched
    import psg_pkg::*;
#(
    parameter  int NCH = 4,
    parameter  int TW  = PSG_TW,
    parameter  int EW  = PSG_EW,
    localparam int OW  = TW + EW,
    localparam int MW  = OW + $clog2(NCH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ce,
    input  logic [NCH-1:0]       chan_en_i,
    input  logic [NCH*TW-1:0]    tgi_i,
    input  logic [NCH*EW-1:0]    env_i,
    input  logic                 ovr_clr_i,
    output logic [NCH*OW-1:0]    o,
`ifdef PSG_SHAPER_SCHED_MIX_EN
    output logic [MW-1:0]        mix_o,
`endif
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 overrun_o
);

    localparam int IW = $clog2(NCH);

    psg_sched_state_e  state_q;
    logic [IW-1:0]     idx_q;
    logic              busy_q;
    logic              done_q;
    logic              ovr_q;
    logic              ovr_d;
    logic [NCH-1:0]    snap_en_q;
    logic [NCH*TW-1:0] snap_tgi_q;
    logic [NCH*EW-1:0] snap_env_q;
    logic [NCH*OW-1:0] o_q;

    logic [TW-1:0]     mul_a;
    logic [EW-1:0]     mul_b;
    logic              mul_vld;
    logic [OW-1:0]     prod;
    logic [IW-1:0]     prod_tag;
    logic              prod_vld;

    // A disabled voice still takes its slot; forcing env to 0 yields a zero product.
    always_comb begin
        mul_a   = snap_tgi_q[idx_q*TW +: TW];
        mul_b   = snap_en_q[idx_q] ? snap_env_q[idx_q*EW +: EW] : '0;
        mul_vld = (state_q == RUN);
    end

    psg_shaper_mul #(
        .AW  (TW),
        .BW  (EW),
        .TGW (IW)
    ) u_mul (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .a_i    (mul_a),
        .b_i    (mul_b),
        .tag_i  (idx_q),
        .vld_i  (mul_vld),
        .prod_o (prod),
        .tag_o  (prod_tag),
        .vld_o  (prod_vld)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            snap_en_q  <= '0;
            snap_tgi_q <= '0;
            snap_env_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ce) begin
                        snap_en_q  <= chan_en_i;
                        snap_tgi_q <= tgi_i;
                        snap_env_q <= env_i;
                        idx_q      <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    if (idx_q == IW'(NCH - 1)) begin
                        state_q <= DRAIN;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DRAIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Overrun set beats clear when both happen in the same cycle.
    always_comb begin
        ovr_d = ovr_q;
        if (ovr_clr_i) begin
            ovr_d = 1'b0;
        end
        if (ce && busy_q) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            o_q <= '0;
        end else if (prod_vld) begin
            o_q[prod_tag*OW +: OW] <= prod;
        end
    end

`ifdef PSG_SHAPER_SCHED_MIX_EN
    logic [MW-1:0] acc_q;
    logic [MW-1:0] mix_q;

    // The final product is still in flight during DRAIN, so fold it in directly.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
            mix_q <= '0;
        end else begin
            if (state_q == IDLE && ce) begin
                acc_q <= '0;
            end else if (prod_vld) begin
                acc_q <= acc_q + MW'(prod);
            end
            if (state_q == DRAIN) begin
                mix_q <= acc_q + MW'(prod);
            end
        end
    end

    assign mix_o = mix_q;
`endif

    assign o         = o_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign overrun_o = ovr_q;

endmodule

// File: tb/tb_psg_shaper_sched.sv
// Directed bench for psg_shaper_sched (NCH=4); checks mix_o when PSG_SHAPER_SCHED_MIX_EN is defined.
module tb_psg_shaper_sched;

    localparam int NCH = 4;
    localparam int OW  = 20;
    localparam int MW  = OW + 2;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            ce = 1'b0;
    logic [3:0]      chan_en_i = '0;
    logic [47:0]     tgi_i = '0;
    logic [31:0]     env_i = '0;
    logic            ovr_clr_i = 1'b0;
    logic [79:0]     o;
    logic            busy_o;
    logic            done_o;
    logic            overrun_o;
`ifdef PSG_SHAPER_SCHED_MIX_EN
    logic [MW-1:0]   mix_o;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    psg_shaper_sched #(.NCH(NCH)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .ce        (ce),
        .chan_en_i (chan_en_i),
        .tgi_i     (tgi_i),
        .env_i     (env_i),
        .ovr_clr_i (ovr_clr_i),
        .o         (o),
`ifdef PSG_SHAPER_SCHED_MIX_EN
        .mix_o     (mix_o),
`endif
        .busy_o    (busy_o),
        .done_o    (done_o),
        .overrun_o (overrun_o)
    );

    typedef struct {
        logic [3:0]  en;
        logic [47:0] tgi;
        logic [31:0] env;
        logic [79:0] exp_o;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [MW-1:0] sum4(input logic [79:0] v);
        logic [MW-1:0] s;
        s = '0;
        for (int k = 0; k < NCH; k++) s = s + MW'(v[k*OW +: OW]);
        return s;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Drives inputs and ce, returns at E0+1.
    task automatic start_frame(input vec_t v);
        chan_en_i = v.en;
        tgi_i     = v.tgi;
        env_i     = v.env;
        ce        = 1'b1;
        step();
        ce        = 1'b0;
    endtask

    // From E0+1 to E5+1, checking timing and outputs. ce_edge>0 pulses ce
    // (with ovr_clr_i if clr) so it is sampled at that edge; scramble changes
    // inputs right after E1.
    task automatic frame(input vec_t v, input string nm, input int ce_edge,
                         input bit clr, input bit scramble);
        chk({nm, ".busy_e0"}, 80'(busy_o), 80'd1);
        for (int k = 1; k <= NCH; k++) begin
            if (ce_edge == k) begin
                ce        = 1'b1;
                ovr_clr_i = clr;
            end
            step();
            ce        = 1'b0;
            ovr_clr_i = 1'b0;
            if (scramble && k == 1) begin
                chan_en_i = ~v.en;
                tgi_i     = ~v.tgi;
                env_i     = ~v.env;
            end
            chk($sformatf("%s.done_e%0d", nm, k), 80'(done_o), 80'd0);
            chk($sformatf("%s.busy_e%0d", nm, k), 80'(busy_o), 80'd1);
            if (ce_edge > 0 && k >= ce_edge)
                chk($sformatf("%s.ovr_e%0d", nm, k), 80'(overrun_o), 80'd1);
        end
        step();
        chk({nm, ".done_e5"}, 80'(done_o), 80'd1);
        chk({nm, ".busy_e5"}, 80'(busy_o), 80'd0);
        chk({nm, ".o"}, o, v.exp_o);
`ifdef PSG_SHAPER_SCHED_MIX_EN
        chk({nm, ".mix"}, 80'(mix_o), 80'(sum4(v.exp_o)));
`endif
    endtask

    initial begin
        vecs[0] = '{4'b1111, 48'h123_001_800_FFF, 32'h00_01_80_FF, 80'h00000_00001_40000_FEF01};
        vecs[1] = '{4'b1011, 48'h123_FFF_800_FFF, 32'h00_FF_80_FF, 80'h00000_00000_40000_FEF01};
        vecs[2] = '{4'b1111, 48'h010_002_100_00A, 32'h10_03_02_05, 80'h00100_00006_00200_00032};
        vecs[3] = '{4'b0000, 48'hABC_DEF_FFF_777, 32'h11_22_FF_99, 80'h0};

        rst_i = 1'b1;
        repeat (3) step();
        chk("rst.o", o, 80'd0);
        chk("rst.busy", 80'(busy_o), 80'd0);
        chk("rst.done", 80'(done_o), 80'd0);
        chk("rst.ovr", 80'(overrun_o), 80'd0);
`ifdef PSG_SHAPER_SCHED_MIX_EN
        chk("rst.mix", 80'(mix_o), 80'd0);
`endif
        rst_i = 1'b0;
        step();

        for (int i = 0; i < 4; i++) begin
            start_frame(vecs[i]);
            frame(vecs[i], $sformatf("vec%0d", i), 0, 1'b0, 1'b0);
            step();
            chk($sformatf("vec%0d.done_e6", i), 80'(done_o), 80'd0);
            tgi_i = ~tgi_i;
            env_i = ~env_i;
            repeat (3) step();
            chk($sformatf("vec%0d.hold", i), o, vecs[i].exp_o);
`ifdef PSG_SHAPER_SCHED_MIX_EN
            chk($sformatf("vec%0d.mix_hold", i), 80'(mix_o), 80'(sum4(vecs[i].exp_o)));
`endif
            chk($sformatf("vec%0d.ovr", i), 80'(overrun_o), 80'd0);
        end

        start_frame(vecs[0]);
        frame(vecs[0], "snap", 0, 1'b0, 1'b1);
        step();

        // Overrun at E2, then a tick plus clear in the done cycle.
        start_frame(vecs[2]);
        frame(vecs[2], "ovr", 2, 1'b0, 1'b0);
        chk("ovr.sticky_e5", 80'(overrun_o), 80'd1);
        chan_en_i = vecs[0].en;
        tgi_i     = vecs[0].tgi;
        env_i     = vecs[0].env;
        ce        = 1'b1;
        ovr_clr_i = 1'b1;
        step();
        ce        = 1'b0;
        ovr_clr_i = 1'b0;
        chk("post.ovr_clr", 80'(overrun_o), 80'd0);
        frame(vecs[0], "post", 0, 1'b0, 1'b0);
        chk("post.ovr_end", 80'(overrun_o), 80'd0);
        step();

        // Overrun and clear together: set wins.
        start_frame(vecs[1]);
        frame(vecs[1], "win", 1, 1'b1, 1'b0);
        step();

        // Reset sampled at E3 abandons the frame.
        start_frame(vecs[2]);
        step();
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("midrst.busy", 80'(busy_o), 80'd0);
        chk("midrst.done", 80'(done_o), 80'd0);
        chk("midrst.o", o, 80'd0);
        chk("midrst.ovr", 80'(overrun_o), 80'd0);
        repeat (4) step();
        chk("midrst.quiet_done", 80'(done_o), 80'd0);
        chk("midrst.quiet_o", o, 80'd0);

        start_frame(vecs[2]);
        frame(vecs[2], "clean", 0, 1'b0, 1'b0);
        step();
        chk("clean.done_e6", 80'(done_o), 80'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
